// File: rtl/ddr_if_pkg.sv
// Shared DDR read-path constants and a constant-evaluable clog2 helper.
package ddr_if_pkg;

  localparam int DDR_BANDWIDTH = 512;
  localparam int DDR_BITWIDTH  = 32;
  localparam int DDR_OUT_WIDTH = 128;
  localparam int DDR_DEPTH     = 512;
  localparam int DDR_R         = DDR_BANDWIDTH / DDR_OUT_WIDTH;
  localparam int DDR_W         = DDR_BANDWIDTH / DDR_BITWIDTH;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr_sync_fifo.sv
// Single-clock beat FIFO with registered read data and a synchronous clear.
module ddr_sync_fifo
  import ddr_if_pkg::*;
#(
  parameter int WIDTH = DDR_BANDWIDTH,
  parameter int DEPTH = DDR_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);

endmodule

// File: rtl/ddr_rd_data_unpack.sv
// DDR read-beat buffer: optional word reversal on write, FIFO storage, and
// LSB-first unpacking of each beat into OUT_WIDTH words over valid/ready.
module ddr_rd_data_unpack
  import ddr_if_pkg::*;
#(
  parameter int BANDWIDTH = DDR_BANDWIDTH,
  parameter int BITWIDTH  = DDR_BITWIDTH,
  parameter int OUT_WIDTH = DDR_OUT_WIDTH,
  parameter int DEPTH     = DDR_DEPTH,
  parameter int AW        = clog2(DEPTH)
) (
  input  logic                 sys_clk_200M,
  input  logic                 sys_rst,
  input  logic                 in_vld,
  input  logic [BANDWIDTH-1:0] in_data,
  input  logic                 cfg_word_rev,
  input  logic [AW:0]          cfg_thresh,
  input  logic                 flush,
  input  logic                 out_rdy,
  output logic                 out_vld,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [AW:0]          fifo_level,
  output logic                 fifo_afull,
  output logic                 fifo_empty,
  output logic                 ovf_err
);

  localparam int R  = BANDWIDTH / OUT_WIDTH;
  localparam int W  = BANDWIDTH / BITWIDTH;
  localparam int KW = (R > 1) ? clog2(R) : 1;

  logic [BANDWIDTH-1:0] rev_data, wr_data, beat;
  logic [OUT_WIDTH-1:0] slice [R];
  logic                 push, pop, fire, at_last, fifo_full;
  logic                 out_vld_q, out_vld_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 avail_q, avail_d;
  logic                 afull_q, afull_d;
  logic                 ovf_q, ovf_d;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
      assign rev_data[gi*BITWIDTH +: BITWIDTH] = in_data[(W-1-gi)*BITWIDTH +: BITWIDTH];
    end
    for (genvar gi = 0; gi < R; gi++) begin : g_slice
      assign slice[gi] = beat[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign wr_data = cfg_word_rev ? rev_data : in_data;
  assign at_last = (k_q == KW'(R-1));
  assign fire    = out_vld_q & out_rdy;
  // The FIFO read register doubles as the unpack register; refill it as the last slice leaves.
  assign pop     = avail_q & ~fifo_empty & ~flush & (~out_vld_q | (at_last & fire));
  assign push    = in_vld & ~flush & (~fifo_full | pop);

  ddr_sync_fifo #(
    .WIDTH (BANDWIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (sys_clk_200M),
    .rst     (sys_rst),
    .clr     (flush),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (beat),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    out_vld_d = out_vld_q;
    k_d       = k_q;
    // A freshly written beat becomes poppable one cycle after it lands.
    avail_d   = (fifo_level != '0) & ~flush;
    afull_d   = (fifo_level > cfg_thresh);
    ovf_d     = ovf_q | (in_vld & fifo_full & ~pop);
    if (flush) begin
      out_vld_d = 1'b0;
      k_d       = '0;
      ovf_d     = 1'b0;
    end else if (pop) begin
      out_vld_d = 1'b1;
      k_d       = '0;
    end else if (fire) begin
      out_vld_d = ~at_last;
      k_d       = at_last ? '0 : k_q + KW'(1);
    end
  end

  always_ff @(posedge sys_clk_200M or posedge sys_rst) begin
    if (sys_rst) begin
      out_vld_q <= 1'b0;
      k_q       <= '0;
      avail_q   <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      k_q       <= k_d;
      avail_q   <= avail_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_data   = out_vld_q ? slice[k_q] : '0;
  assign out_last   = out_vld_q & at_last;
  assign fifo_afull = afull_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_ddr_rd_data_unpack.sv
// Directed bench for ddr_rd_data_unpack: latency, word reversal, stalls,
// fill/overflow, flush and asynchronous reset.
module tb_ddr_rd_data_unpack;

  logic         clk = 1'b0;
  logic         sys_rst;
  logic         in_vld;
  logic [511:0] in_data;
  logic         cfg_word_rev;
  logic [9:0]   cfg_thresh;
  logic         flush;
  logic         out_rdy;
  logic         out_vld;
  logic [127:0] out_data;
  logic         out_last;
  logic [9:0]   fifo_level;
  logic         fifo_afull;
  logic         fifo_empty;
  logic         ovf_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ddr_rd_data_unpack dut (
    .sys_clk_200M (clk),
    .sys_rst      (sys_rst),
    .in_vld       (in_vld),
    .in_data      (in_data),
    .cfg_word_rev (cfg_word_rev),
    .cfg_thresh   (cfg_thresh),
    .flush        (flush),
    .out_rdy      (out_rdy),
    .out_vld      (out_vld),
    .out_data     (out_data),
    .out_last     (out_last),
    .fifo_level   (fifo_level),
    .fifo_afull   (fifo_afull),
    .fifo_empty   (fifo_empty),
    .ovf_err      (ovf_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat whose 32-bit word i holds base+i.
  function automatic logic [511:0] mk(input int base);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + i;
    return b;
  endfunction

  // Expected output slice j of beat mk(base), written with or without reversal.
  function automatic logic [127:0] exp_slice(input int base, input int j, input bit rev);
    logic [127:0] s;
    for (int q = 0; q < 4; q++) begin
      int p;
      p = j * 4 + q;
      s[q*32 +: 32] = rev ? base + 15 - p : base + p;
    end
    return s;
  endfunction

  function automatic int lvl_model(input int n);
    if (n < 3) return n;
    return (n - 1 > 512) ? 512 : n - 1;
  endfunction

  task automatic single_beat(input int base, input bit rev);
    in_vld = 1'b1; in_data = mk(base); cfg_word_rev = rev; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0; cfg_word_rev = 1'b0;
    chk("lat_e0_vld", out_vld, 0);
    tick();
    chk("lat_e1_vld", out_vld, 0);
    tick();
    chk("lat_e2_vld", out_vld, 1);
    for (int j = 0; j < 4; j++) begin
      chk("beat_word", out_data, exp_slice(base, j, rev));
      chk("beat_last", out_last, (j == 3));
      tick();
    end
    chk("beat_drained_vld", out_vld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] q_exp[$];
    logic [127:0] prev_data;
    logic         prev_last;
    logic         stall_prev;
    logic         started;
    int           acc;

    sys_rst = 1'b1; in_vld = 1'b0; in_data = '0; cfg_word_rev = 1'b0;
    cfg_thresh = 10'd256; flush = 1'b0; out_rdy = 1'b0;
    tick();
    tick();
    chk("rst_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_afull", fifo_afull, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_ovf", ovf_err, 0);
    sys_rst = 1'b0;
    tick();

    // 1 and 2: single beat, plain then word-reversed
    single_beat(0, 1'b0);
    single_beat(0, 1'b1);

    // 3: eight back-to-back beats under random ready
    started = 1'b0; stall_prev = 1'b0; acc = 0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < 300 && acc < 32; c++) begin
      if (stall_prev) begin
        chk("stall_vld", out_vld, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_vld) started = 1'b1;
      if (started) chk("no_bubble_vld", out_vld, 1);
      if (c < 8) begin
        in_vld = 1'b1; in_data = mk(16 * (c + 1)); cfg_word_rev = c[0];
        for (int j = 0; j < 4; j++) q_exp.push_back(exp_slice(16 * (c + 1), j, c[0]));
      end else begin
        in_vld = 1'b0; cfg_word_rev = 1'b0;
      end
      out_rdy = 1'($urandom_range(0, 1));
      if (out_vld && out_rdy) begin
        if (q_exp.size() == 0) chk("extra_word", out_data, 0);
        else chk("stream_word", out_data, q_exp.pop_front());
        chk("stream_last", out_last, (acc % 4 == 3));
        acc++;
      end
      stall_prev = out_vld && !out_rdy;
      prev_data = out_data; prev_last = out_last;
      tick();
    end
    chk("stream_count", acc, 32);
    in_vld = 1'b0; out_rdy = 1'b0;
    tick();
    chk("stream_end_vld", out_vld, 0);
    chk("stream_end_level", fifo_level, 0);

    // 4: fill with ready low, threshold 256, 514 pushes
    for (int n = 1; n <= 514; n++) begin
      in_vld = 1'b1; in_data = mk(16 * n);
      tick();
      chk("fill_level", fifo_level, lvl_model(n));
      chk("fill_afull", fifo_afull, (lvl_model(n - 1) > 256));
      if (n == 513) chk("fill_ovf_513", ovf_err, 0);
      if (n == 514) chk("fill_ovf_514", ovf_err, 1);
    end
    in_vld = 1'b0;
    tick();
    tick();
    chk("ovf_sticky", ovf_err, 1);
    chk("full_level_hold", fifo_level, 512);
    chk("full_ureg_vld", out_vld, 1);
    chk("full_ureg_data", out_data, exp_slice(16, 0, 1'b0));

    // 5: flush mid-beat with a beat offered in the same cycle
    out_rdy = 1'b1;
    tick();
    tick();
    chk("pre_flush_data", out_data, exp_slice(16, 2, 1'b0));
    flush = 1'b1; in_vld = 1'b1; in_data = mk(9000);
    tick();
    flush = 1'b0; in_vld = 1'b0;
    chk("flush_vld", out_vld, 0);
    chk("flush_level", fifo_level, 0);
    chk("flush_empty", fifo_empty, 1);
    chk("flush_ovf", ovf_err, 0);
    single_beat(5000, 1'b0);
    chk("post_flush_level", fifo_level, 0);

    // 6: asynchronous reset mid-burst
    out_rdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_vld = 1'b1; in_data = mk(6000 + 16 * b);
      tick();
    end
    in_vld = 1'b0;
    chk("burst_vld", out_vld, 1);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("arst_vld", out_vld, 0);
    chk("arst_data", out_data, 0);
    chk("arst_last", out_last, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_empty", fifo_empty, 1);
    chk("arst_ovf", ovf_err, 0);
    tick();
    sys_rst = 1'b0;
    tick();
    single_beat(7000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
